// File: rtl/tartaruga_pkg.sv
// Shared types and defaults for the execute-stage latency pipe.
package tartaruga_pkg;

  localparam int MAX_EXE_STAGES = 4;
  localparam int EXE_PAYLOAD_W  = 96;
  localparam int EXE_REG_ADDR_W = 5;

  typedef struct packed {
    logic                      valid;
    logic [EXE_REG_ADDR_W-1:0] rd;
    logic                      we;
    logic                      iter;
    logic [EXE_PAYLOAD_W-1:0]  payload;
  } exe_slot_t;

  localparam exe_slot_t EXE_SLOT_NONE = '0;

endpackage

// File: rtl/exe_busy_counter.sv
// Occupancy counter for the non-pipelined iterative unit: load on issue,
// count down while the pipe advances, clear on flush.
module exe_busy_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != {W{1'b0}});

endmodule

// File: rtl/exe_latency_pipe.sv
// Execute-stage tracking pipe: variable-latency issue into a shift array that
// retires in order through one writeback slot, with RAW hazard reporting.
module exe_latency_pipe
  import tartaruga_pkg::*;
#(
  parameter int MAX_LAT    = MAX_EXE_STAGES,
  parameter int PAYLOAD_W  = EXE_PAYLOAD_W,
  parameter int REG_ADDR_W = EXE_REG_ADDR_W,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [LAT_W-1:0]      issue_lat_i,
  input  logic                  issue_iter_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_we_i,
  input  logic [PAYLOAD_W-1:0]  issue_pay_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o,
  output logic                  illegal_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [REG_ADDR_W-1:0] out_rd_o,
  output logic                  out_we_o,
  output logic [PAYLOAD_W-1:0]  out_pay_o,
  input  logic                  flush_i,
  output logic [LAT_W-1:0]      occupancy_o
);

  exe_slot_t        slot_q [MAX_LAT];
  exe_slot_t        slot_d [MAX_LAT];
  exe_slot_t        new_slot;
  logic [LAT_W-1:0] occ_q;
  logic [LAT_W-1:0] occ_d;
  logic             lat_ok;
  logic             adv;
  logic             collision;
  logic             iter_busy;
  logic             accept;

  assign lat_ok    = (issue_lat_i != {LAT_W{1'b0}}) && (int'(issue_lat_i) <= MAX_LAT);
  assign illegal_o = issue_valid_i & ~lat_ok;
  assign adv       = ~slot_q[MAX_LAT-1].valid | out_ready_i;

  // Target slot t = MAX_LAT-L receives s[t-1] on the shift; L == MAX_LAT lands in s[0] and never collides.
  always_comb begin
    collision = ~lat_ok;
    for (int j = 0; j < MAX_LAT - 1; j++) begin
      collision = collision | ((int'(issue_lat_i) == MAX_LAT - 1 - j) & slot_q[j].valid);
    end
  end

  assign issue_ready_o = ~rst_i & adv & ~flush_i & ~collision & ~illegal_o
                       & ~(issue_iter_i & iter_busy);
  assign accept        = issue_valid_i & issue_ready_o;

  // Entry built from the decode-side fields.
  always_comb begin
    new_slot         = EXE_SLOT_NONE;
    new_slot.valid   = 1'b1;
    new_slot.rd      = issue_rd_i;
    new_slot.we      = issue_we_i;
    new_slot.iter    = issue_iter_i;
    new_slot.payload = issue_pay_i;
  end

  // Slot array next state: flush clears, advance shifts and drops the new entry at its target.
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_d[i] = EXE_SLOT_NONE;
      end
    end else if (adv) begin
      slot_d[0] = EXE_SLOT_NONE;
      for (int i = 1; i < MAX_LAT; i++) begin
        slot_d[i] = slot_q[i-1];
      end
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_d[i] = (accept && (int'(issue_lat_i) == MAX_LAT - i)) ? new_slot : slot_d[i];
      end
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_d[i] = slot_q[i];
      end
    end
  end

  // Popcount of the next slot valids, registered alongside the slots.
  always_comb begin
    occ_d = {LAT_W{1'b0}};
    for (int i = 0; i < MAX_LAT; i++) begin
      occ_d = occ_d + LAT_W'(slot_d[i].valid);
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_q[i] <= EXE_SLOT_NONE;
      end
      occ_q <= {LAT_W{1'b0}};
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot_q[i] <= slot_d[i];
      end
      occ_q <= occ_d;
    end
  end

  // RAW check against every valid in-flight entry, writeback slot included.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      hazard_o = hazard_o | (slot_q[i].valid & slot_q[i].we
                 & (slot_q[i].rd != {REG_ADDR_W{1'b0}})
                 & ((slot_q[i].rd == rs1_i) | (slot_q[i].rd == rs2_i)));
    end
  end

  exe_busy_counter #(.W(LAT_W)) u_busy (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush_i),
    .load_i     (accept & issue_iter_i),
    .load_val_i (issue_lat_i - LAT_W'(1)),
    .dec_i      (adv),
    .busy_o     (iter_busy)
  );

  assign out_valid_o = slot_q[MAX_LAT-1].valid & ~flush_i;
  assign out_rd_o    = slot_q[MAX_LAT-1].rd;
  assign out_we_o    = slot_q[MAX_LAT-1].we;
  assign out_pay_o   = slot_q[MAX_LAT-1].payload;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_exe_latency_pipe.sv
// Randomized and directed bench for exe_latency_pipe against an entry-list model
// where each in-flight entry carries its remaining cycles to writeback.
module tb_exe_latency_pipe;

  localparam int MAX_LAT = 4;
  localparam int LAT_W   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [2:0]  issue_lat_i;
  logic        issue_iter_i;
  logic [4:0]  issue_rd_i;
  logic        issue_we_i;
  logic [95:0] issue_pay_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        hazard_o;
  logic        illegal_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  out_rd_o;
  logic        out_we_o;
  logic [95:0] out_pay_o;
  logic        flush_i;
  logic [2:0]  occupancy_o;

  int n_err = 0;
  int n_checks = 0;

  exe_latency_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_lat_i(issue_lat_i), .issue_iter_i(issue_iter_i), .issue_rd_i(issue_rd_i),
    .issue_we_i(issue_we_i), .issue_pay_i(issue_pay_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .hazard_o(hazard_o), .illegal_o(illegal_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_rd_o(out_rd_o), .out_we_o(out_we_o),
    .out_pay_o(out_pay_o), .flush_i(flush_i), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          rem;
    logic [4:0]  rd;
    logic        we;
    logic [95:0] pay;
  } ent_t;

  ent_t q[$];
  int   m_busy = 0;

  // Model + compare: evaluate at the falling edge, then advance as the coming rising edge will.
  initial begin
    ent_t nq[$];
    ent_t e;
    int   wb;
    bit   e_adv, e_ill, e_coll, e_ready, e_hz, e_outv, lat_legal;
    forever begin
      @(negedge clk_i);
      wb = -1;
      foreach (q[i]) if (q[i].rem == 0) wb = i;
      lat_legal = (issue_lat_i >= 3'd1) && (int'(issue_lat_i) <= MAX_LAT);
      e_adv  = (wb < 0) || out_ready_i;
      e_ill  = issue_valid_i && !lat_legal;
      e_coll = 1'b0;
      foreach (q[i]) if (q[i].rem == int'(issue_lat_i)) e_coll = 1'b1;
      e_ready = !rst_i && e_adv && !flush_i && !e_coll && !e_ill && !(issue_iter_i && m_busy != 0);
      e_hz = 1'b0;
      foreach (q[i])
        if (q[i].we && q[i].rd != 5'd0 && (q[i].rd == rs1_i || q[i].rd == rs2_i)) e_hz = 1'b1;
      e_outv = (wb >= 0) && !flush_i;

      chk("m_illegal", illegal_o, e_ill);
      if (issue_valid_i || lat_legal) chk("m_ready", issue_ready_o, e_ready);
      chk("m_hazard", hazard_o, e_hz);
      chk("m_out_valid", out_valid_o, e_outv);
      chk("m_occupancy", occupancy_o, q.size());
      if (e_outv) begin
        chk("m_out_rd", out_rd_o, q[wb].rd);
        chk("m_out_we", out_we_o, q[wb].we);
        chk("m_out_pay", out_pay_o, q[wb].pay);
      end

      if (rst_i || flush_i) begin
        q.delete();
        m_busy = 0;
      end else if (e_adv) begin
        nq.delete();
        foreach (q[i]) begin
          if (q[i].rem > 0) begin
            e = q[i];
            e.rem--;
            nq.push_back(e);
          end
        end
        if (issue_valid_i && e_ready) begin
          e.rem = int'(issue_lat_i) - 1;
          e.rd  = issue_rd_i;
          e.we  = issue_we_i;
          e.pay = issue_pay_i;
          nq.push_back(e);
        end
        q = nq;
        if (issue_valid_i && e_ready && issue_iter_i) m_busy = int'(issue_lat_i) - 1;
        else if (m_busy > 0) m_busy--;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_lat_i = 3'd0; issue_iter_i = 1'b0; issue_rd_i = 5'd0;
    issue_we_i = 1'b0; issue_pay_i = 96'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    out_ready_i = 1'b1; flush_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic offer(input int l, input bit it, input int r, input bit w, input logic [95:0] p);
    issue_valid_i = 1'b1; issue_lat_i = 3'(l); issue_iter_i = it;
    issue_rd_i = 5'(r); issue_we_i = w; issue_pay_i = p;
  endtask

  task automatic drain();
    idle();
    repeat (6) step();
  endtask

  localparam logic [95:0] PA = 96'hA0A0_0000_0000_0000_0000_00A1;
  localparam logic [95:0] PB = 96'hB0B0_0000_1111_2222_3333_00B2;
  localparam logic [95:0] PC = 96'hC0C0_DEAD_BEEF_0000_0000_00C3;

  initial begin
    int r;
    idle();
    rst_i = 1'b1;
    offer(1, 1'b0, 3, 1'b1, 96'd1);
    step(); #1 chk("rst_ready", issue_ready_o, 1'b0);
    step(); idle();
    step(); #1 chk("rst_out_valid", out_valid_o, 1'b0); chk("rst_occ", occupancy_o, 3'd0);
    chk("rst_hazard", hazard_o, 1'b0);

    // latency mix
    step(); idle(); offer(3, 1'b0, 1, 1'b1, PA); #1 chk("mix_l3_ready", issue_ready_o, 1'b1);
    step(); idle(); offer(2, 1'b0, 2, 1'b1, PB); #1 chk("mix_l2_collide", issue_ready_o, 1'b0);
    issue_lat_i = 3'd4; #1 chk("mix_l4_ready", issue_ready_o, 1'b1);
    step(); idle(); #1 chk("mix_c2_outv", out_valid_o, 1'b0);
    step(); #1 chk("mix_c3_outv", out_valid_o, 1'b1); chk("mix_c3_pay", out_pay_o, PA);
    step(); #1 chk("mix_c4_outv", out_valid_o, 1'b0);
    step(); #1 chk("mix_c5_outv", out_valid_o, 1'b1); chk("mix_c5_pay", out_pay_o, PB);
    drain();

    // backpressure
    step(); idle(); offer(2, 1'b0, 3, 1'b1, PC); #1 chk("bp_issue_ready", issue_ready_o, 1'b1);
    step(); idle();
    step(); out_ready_i = 1'b0; offer(4, 1'b0, 4, 1'b1, 96'hD);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_hold_valid", out_valid_o, 1'b1); chk("bp_hold_pay", out_pay_o, PC);
      chk("bp_hold_ready", issue_ready_o, 1'b0);
      step();
    end
    out_ready_i = 1'b1;
    #1 chk("bp_release_valid", out_valid_o, 1'b1); chk("bp_release_ready", issue_ready_o, 1'b1);
    drain();

    // iterative unit
    step(); idle(); offer(4, 1'b1, 6, 1'b1, 96'hE); #1 chk("iter_first", issue_ready_o, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(); idle(); offer(2, 1'b1, 7, 1'b1, 96'hF); #1 chk("iter_blocked", issue_ready_o, 1'b0);
    end
    step(); #1 chk("iter_accept_c4", issue_ready_o, 1'b1);
    drain();

    // hazards
    step(); idle(); offer(4, 1'b0, 5, 1'b1, 96'h10);
    step(); idle(); offer(4, 1'b0, 0, 1'b1, 96'h11); rs1_i = 5'd5; #1 chk("hz_rs1", hazard_o, 1'b1);
    rs1_i = 5'd6; rs2_i = 5'd5; #1 chk("hz_rs2", hazard_o, 1'b1);
    step(); idle(); offer(4, 1'b0, 9, 1'b0, 96'h12); rs2_i = 5'd9; #1 chk("hz_rd0", hazard_o, 1'b0);
    step(); idle(); rs2_i = 5'd9; #1 chk("hz_we0", hazard_o, 1'b0);
    step(); idle(); rs1_i = 5'd5; #1 chk("hz_wb_slot", hazard_o, 1'b1);
    step(); idle(); rs1_i = 5'd5; #1 chk("hz_after_wb", hazard_o, 1'b0);
    drain();

    // flush with a full pipe
    for (int k = 0; k < 4; k++) begin
      step(); idle(); offer(4, 1'b0, k + 1, 1'b1, 96'(k + 32));
    end
    step(); idle(); #1 chk("fl_occ_full", occupancy_o, 3'd4);
    flush_i = 1'b1; offer(4, 1'b0, 1, 1'b1, 96'h44);
    #1 chk("fl_out_masked", out_valid_o, 1'b0); chk("fl_ready", issue_ready_o, 1'b0);
    step(); idle(); #1 chk("fl_occ_zero", occupancy_o, 3'd0); chk("fl_outv_zero", out_valid_o, 1'b0);

    // illegal latencies
    step(); idle(); offer(4, 1'b0, 2, 1'b1, 96'h50);
    step(); idle(); offer(0, 1'b0, 2, 1'b1, 96'h51);
    #1 chk("ill_l0", illegal_o, 1'b1); chk("ill_l0_ready", issue_ready_o, 1'b0);
    chk("ill_l0_occ", occupancy_o, 3'd1);
    step(); idle(); offer(5, 1'b0, 2, 1'b1, 96'h52);
    #1 chk("ill_l5", illegal_o, 1'b1); chk("ill_l5_ready", issue_ready_o, 1'b0);
    chk("ill_l5_occ", occupancy_o, 3'd1);
    step(); idle(); #1 chk("ill_occ_after", occupancy_o, 3'd1);
    drain();

    // reset mid-stream
    step(); idle(); offer(4, 1'b1, 3, 1'b1, 96'h60);
    step(); idle(); offer(4, 1'b0, 4, 1'b1, 96'h61);
    step(); idle(); offer(4, 1'b0, 5, 1'b1, 96'h62);
    step(); idle(); #1 chk("rm_occ3", occupancy_o, 3'd3); rst_i = 1'b1;
    step(); idle(); offer(4, 1'b1, 6, 1'b1, 96'h63);
    #1 chk("rm_outv", out_valid_o, 1'b0); chk("rm_occ0", occupancy_o, 3'd0);
    chk("rm_iter_ready", issue_ready_o, 1'b1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      r = int'($urandom_range(0, 19));
      issue_valid_i = ($urandom_range(0, 9) < 7);
      issue_lat_i   = (r == 0) ? 3'd0 : (r == 1) ? 3'd5 : 3'(1 + (r % 4));
      issue_iter_i  = ($urandom_range(0, 3) == 0);
      issue_rd_i    = 5'($urandom_range(0, 7));
      issue_we_i    = ($urandom_range(0, 3) != 0);
      issue_pay_i   = {$urandom, $urandom, $urandom};
      rs1_i         = 5'($urandom_range(0, 7));
      rs2_i         = 5'($urandom_range(0, 7));
      out_ready_i   = ($urandom_range(0, 9) < 7);
      flush_i       = ($urandom_range(0, 49) == 0);
      rst_i         = ($urandom_range(0, 99) == 0);
    end
    step(); idle();
    step();
    #2 $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
